// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one synchronous RAM port between the CPU and the program loader
module ram_port_arbiter #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  input  logic              cpu_lock_i,
  input  logic              ldr_mode_i,
  input  logic              ldr_req_i,
  input  logic              ldr_we_i,
  input  logic [ADDR_W-1:0] ldr_addr_i,
  input  logic [DATA_W-1:0] ldr_wdata_i,
  output logic              cpu_gnt_o,
  output logic              ldr_gnt_o,
  output logic              cpu_rvalid_o,
  output logic              ldr_rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              cpu_hold_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] MAXW = WW'(MAX_WAIT);
  typedef enum logic [1:0] {IDLE, CPU, LDR} owner_t;
  owner_t owner_q, owner_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic cpu_gnt_q, cpu_gnt_d, ldr_gnt_q, ldr_gnt_d;
  logic cpu_rv_q, cpu_rv_d, ldr_rv_q, ldr_rv_d;
  logic cpu_hold_q, cpu_hold_d, ram_en_q, ram_en_d, ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic cpu_elig, ldr_elig, locked;
  // a requester granted this cycle is still holding req as its acknowledge, so it sits out one edge
  assign cpu_elig = cpu_req_i && !cpu_gnt_q && !cpu_hold_q;
  assign ldr_elig = ldr_req_i && !ldr_gnt_q;
  assign locked   = owner_q == CPU && cpu_lock_i;
  always_comb begin
    cpu_gnt_d   = locked ? cpu_elig : cpu_elig && (wait_cnt_q == MAXW || !ldr_elig);
    ldr_gnt_d   = !locked && ldr_elig && !cpu_gnt_d;
    owner_d     = (locked || cpu_gnt_d) ? CPU : ldr_gnt_d ? LDR : IDLE;
    wait_cnt_d  = cpu_hold_q ? wait_cnt_q :
                  (cpu_gnt_d || !cpu_req_i) ? '0 :
                  (cpu_elig && wait_cnt_q != MAXW) ? wait_cnt_q + WW'(1) : wait_cnt_q;
    cpu_hold_d  = !ldr_mode_i ? 1'b0 : !locked ? 1'b1 : cpu_hold_q;
    ram_en_d    = cpu_gnt_d || ldr_gnt_d;
    ram_we_d    = cpu_gnt_d ? cpu_we_i : ldr_gnt_d && ldr_we_i;
    ram_addr_d  = cpu_gnt_d ? cpu_addr_i : ldr_gnt_d ? ldr_addr_i : '0;
    ram_wdata_d = cpu_gnt_d ? cpu_wdata_i : ldr_gnt_d ? ldr_wdata_i : '0;
    cpu_rv_d    = cpu_gnt_q && !ram_we_q;
    ldr_rv_d    = ldr_gnt_q && !ram_we_q;
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      owner_q     <= IDLE;
      wait_cnt_q  <= '0;
      cpu_gnt_q   <= 1'b0;
      ldr_gnt_q   <= 1'b0;
      cpu_rv_q    <= 1'b0;
      ldr_rv_q    <= 1'b0;
      cpu_hold_q  <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      owner_q     <= owner_d;
      wait_cnt_q  <= wait_cnt_d;
      cpu_gnt_q   <= cpu_gnt_d;
      ldr_gnt_q   <= ldr_gnt_d;
      cpu_rv_q    <= cpu_rv_d;
      ldr_rv_q    <= ldr_rv_d;
      cpu_hold_q  <= cpu_hold_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end
  assign cpu_gnt_o    = cpu_gnt_q;
  assign ldr_gnt_o    = ldr_gnt_q;
  assign cpu_rvalid_o = cpu_rv_q;
  assign ldr_rvalid_o = ldr_rv_q;
  assign cpu_hold_o   = cpu_hold_q;
  assign ram_en_o     = ram_en_q;
  assign ram_we_o     = ram_we_q;
  assign ram_addr_o   = ram_addr_q;
  assign ram_wdata_o  = ram_wdata_q;
  // gated so rdata reads 0 whenever no read is being returned, including during reset
  assign rdata_o      = (cpu_rv_q || ldr_rv_q) ? ram_rdata_i : '0;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed scenarios for the RAM port arbiter with a behavioural synchronous RAM
module tb_ram_port_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic cpu_req = 1'b0, cpu_we = 1'b0, cpu_lock = 1'b0;
  logic [3:0] cpu_addr = '0, ldr_addr = '0;
  logic [7:0] cpu_wdata = '0, ldr_wdata = '0;
  logic ldr_mode = 1'b0, ldr_req = 1'b0, ldr_we = 1'b0;
  logic cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid, cpu_hold, ram_en, ram_we;
  logic [3:0] ram_addr;
  logic [7:0] rdata, ram_wdata, ram_rdata = '0;
  logic [7:0] mem [16];
  int checks = 0, failures = 0;
  // flags = {cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid, cpu_hold, ram_en, ram_we}
  wire [6:0] flags = {cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid, cpu_hold, ram_en, ram_we};

  ram_port_arbiter dut (
    .clk_i(clk), .reset_i(reset),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_lock_i(cpu_lock), .ldr_mode_i(ldr_mode),
    .ldr_req_i(ldr_req), .ldr_we_i(ldr_we), .ldr_addr_i(ldr_addr), .ldr_wdata_i(ldr_wdata),
    .cpu_gnt_o(cpu_gnt), .ldr_gnt_o(ldr_gnt), .cpu_rvalid_o(cpu_rvalid), .ldr_rvalid_o(ldr_rvalid),
    .rdata_o(rdata), .cpu_hold_o(cpu_hold), .ram_en_o(ram_en), .ram_we_o(ram_we),
    .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else ram_rdata <= mem[ram_addr];
    end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if (flags !== 7'b0 || ram_addr !== 4'h0 || ram_wdata !== 8'h0 || rdata !== 8'h0) begin
      failures++;
      $display("FAIL reset_state flags=%b addr=%h wdata=%h rdata=%h required all zero", flags, ram_addr, ram_wdata, rdata);
    end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_cpu_read;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'h9; cpu_wdata = 8'h0B;
    tick;
    checks++;
    if (flags !== 7'b1000011 || ram_addr !== 4'h9 || ram_wdata !== 8'h0B) begin
      failures++;
      $display("FAIL cpu_write_grant flags=%b addr=%h wdata=%h required 1000011/9/0b", flags, ram_addr, ram_wdata);
    end
    cpu_req = 1'b0;
    tick;
    checks++;
    if (flags !== 7'b0) begin
      failures++;
      $display("FAIL cpu_write_no_rvalid flags=%b required 0000000", flags);
    end
    cpu_req = 1'b1; cpu_we = 1'b0;
    tick;
    checks++;
    if (flags !== 7'b1000010 || ram_addr !== 4'h9) begin
      failures++;
      $display("FAIL cpu_read_grant flags=%b addr=%h required 1000010/9", flags, ram_addr);
    end
    cpu_req = 1'b0;
    tick;
    checks++;
    if (flags !== 7'b0010000 || rdata !== 8'h0B) begin
      failures++;
      $display("FAIL cpu_read_rvalid flags=%b rdata=%h required 0010000/0b", flags, rdata);
    end
    tick;
  endtask

  task automatic test_reset_mid_read;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h9;
    tick;
    cpu_req = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (flags !== 7'b0 || ram_addr !== 4'h0 || rdata !== 8'h0) begin
      failures++;
      $display("FAIL reset_mid_read flags=%b addr=%h rdata=%h required all zero", flags, ram_addr, rdata);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick;
      checks++;
      if (flags !== 7'b0) begin
        failures++;
        $display("FAIL reset_drops_rvalid cycle=%0d flags=%b required 0000000", i, flags);
      end
    end
  endtask

  task automatic test_contention;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h1;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 4'h2;
    for (int i = 0; i < 6; i++) begin
      logic exp_ldr;
      exp_ldr = (i % 2) == 0;
      tick;
      checks++;
      if ({cpu_gnt, ldr_gnt} !== {!exp_ldr, exp_ldr} || ram_addr !== (exp_ldr ? 4'h2 : 4'h1)) begin
        failures++;
        $display("FAIL contention edge=%0d cpu_gnt=%b ldr_gnt=%b addr=%h required ldr=%b", i, cpu_gnt, ldr_gnt, ram_addr, exp_ldr);
      end
      checks++;
      if (dut.wait_cnt_q == 2'd3) begin
        failures++;
        $display("FAIL contention_wait edge=%0d wait_cnt=%0d required below 3", i, dut.wait_cnt_q);
      end
    end
    cpu_req = 1'b0; ldr_req = 1'b0;
    repeat (3) tick;
  endtask

  task automatic test_starvation;
    force dut.ldr_elig = 1'b1;
    cpu_req = 1'b1; cpu_addr = 4'h3; ldr_req = 1'b1; ldr_addr = 4'h4;
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++;
      if ({cpu_gnt, ldr_gnt} !== ((i == 3) ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL starvation edge=%0d cpu_gnt=%b ldr_gnt=%b required cpu=%b", i, cpu_gnt, ldr_gnt, i == 3);
      end
    end
    release dut.ldr_elig;
    cpu_req = 1'b0; ldr_req = 1'b0;
    repeat (3) tick;
  endtask

  task automatic test_lock;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'h5; cpu_wdata = 8'h55; cpu_lock = 1'b1;
    tick;
    checks++;
    if (flags !== 7'b1000011 || ram_addr !== 4'h5) begin
      failures++;
      $display("FAIL lock_first_write flags=%b addr=%h required 1000011/5", flags, ram_addr);
    end
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 4'hA;
    cpu_addr = 4'h6; cpu_wdata = 8'h66;
    tick;
    checks++;
    if (flags !== 7'b0) begin
      failures++;
      $display("FAIL lock_idle_gap flags=%b required 0000000", flags);
    end
    tick;
    checks++;
    if (flags !== 7'b1000011 || ram_addr !== 4'h6 || ram_wdata !== 8'h66) begin
      failures++;
      $display("FAIL lock_second_write flags=%b addr=%h wdata=%h required 1000011/6/66", flags, ram_addr, ram_wdata);
    end
    cpu_req = 1'b0;
    tick;
    checks++;
    if (ldr_gnt !== 1'b0) begin
      failures++;
      $display("FAIL lock_blocks_loader ldr_gnt=%b required 0", ldr_gnt);
    end
    cpu_lock = 1'b0;
    tick;
    checks++;
    if (ldr_gnt !== 1'b1 || ram_addr !== 4'hA || ram_we !== 1'b0) begin
      failures++;
      $display("FAIL unlock_loader_grant ldr_gnt=%b addr=%h we=%b required 1/a/0", ldr_gnt, ram_addr, ram_we);
    end
    ldr_req = 1'b0;
    tick;
    checks++;
    if (mem[5] !== 8'h55 || mem[6] !== 8'h66) begin
      failures++;
      $display("FAIL lock_ram_contents mem5=%h mem6=%h required 55/66", mem[5], mem[6]);
    end
    repeat (2) tick;
  endtask

  task automatic test_loader_session;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h3; cpu_lock = 1'b1;
    tick;
    checks++;
    if (cpu_gnt !== 1'b1) begin
      failures++;
      $display("FAIL session_lock_grant cpu_gnt=%b required 1", cpu_gnt);
    end
    cpu_req = 1'b0; ldr_mode = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick;
      checks++;
      if (cpu_hold !== 1'b0) begin
        failures++;
        $display("FAIL hold_deferred_by_lock edge=%0d cpu_hold=%b required 0", i, cpu_hold);
      end
    end
    cpu_lock = 1'b0;
    tick;
    checks++;
    if (cpu_hold !== 1'b1) begin
      failures++;
      $display("FAIL hold_after_unlock cpu_hold=%b required 1", cpu_hold);
    end
    cpu_req = 1'b1;
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 4'h0; ldr_wdata = 8'h10;
    for (int i = 0; i < 7; i++) begin
      tick;
      checks++;
      if (flags !== 7'b0100111 || ram_addr !== 4'(i) || ram_wdata !== 8'(8'h10 + i)) begin
        failures++;
        $display("FAIL loader_write i=%0d flags=%b addr=%h wdata=%h required 0100111/%h/%h", i, flags, ram_addr, ram_wdata, 4'(i), 8'(8'h10 + i));
      end
      ldr_addr = 4'(i + 1); ldr_wdata = 8'(8'h11 + i);
      tick;
      checks++;
      if ({cpu_gnt, ldr_gnt} !== 2'b00) begin
        failures++;
        $display("FAIL loader_gap i=%0d cpu_gnt=%b ldr_gnt=%b required 00", i, cpu_gnt, ldr_gnt);
      end
    end
    ldr_req = 1'b0; ldr_mode = 1'b0;
    tick;
    checks++;
    if (cpu_hold !== 1'b0 || cpu_gnt !== 1'b0) begin
      failures++;
      $display("FAIL hold_release cpu_hold=%b cpu_gnt=%b required 0/0", cpu_hold, cpu_gnt);
    end
    tick;
    checks++;
    if (cpu_gnt !== 1'b1 || ram_addr !== 4'h3) begin
      failures++;
      $display("FAIL cpu_resume cpu_gnt=%b addr=%h required 1/3", cpu_gnt, ram_addr);
    end
    cpu_req = 1'b0;
    tick;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (mem[i] !== 8'(8'h10 + i)) begin
        failures++;
        $display("FAIL loader_ram i=%0d got=%h required %h", i, mem[i], 8'(8'h10 + i));
      end
    end
  endtask

  initial begin
    test_reset;
    test_cpu_read;
    test_reset_mid_read;
    test_contention;
    test_starvation;
    test_lock;
    test_loader_session;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
